// File: rtl/alu_operand_stack.sv
// Operand stack feeding ALU operands (TOS/NOS) and committing results.
// Optional high-water mark output: define ALU_OPERAND_STACK_HWM_EN.
module alu_operand_stack #(
  parameter int DBITS = 32,
  parameter int DEPTH = 16,
  parameter int PBITS = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       stack_op,
  input  logic [DBITS-1:0] push_data,
  input  logic [DBITS-1:0] alu_result,
  output logic [DBITS-1:0] operand1,
  output logic [DBITS-1:0] operand2,
  output logic [PBITS-1:0] depth,
  output logic             empty,
  output logic             full,
  output logic             error,
  output logic [1:0]       err_code
`ifdef ALU_OPERAND_STACK_HWM_EN
  ,
  output logic [PBITS-1:0] hwm
`endif
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_PSH = 3'b001;
  localparam logic [2:0] OP_POP = 3'b010;
  localparam logic [2:0] OP_BIN = 3'b011;
  localparam logic [2:0] OP_UNA = 3'b100;
  localparam logic [2:0] OP_DUP = 3'b101;
  localparam logic [2:0] OP_SWP = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  localparam logic [1:0] E_UND = 2'b01;
  localparam logic [1:0] E_OVF = 2'b10;

  logic [DBITS-1:0] mem_q [DEPTH];
  logic [PBITS-1:0] depth_q, depth_d;
  logic             error_q, error_d;
  logic [1:0]       code_q, code_d;

  logic [PBITS-1:0] p_tos, p_nos;
  logic [AW-1:0]    a_new, a_tos, a_nos;
  logic             ge1, ge2, is_full;
  logic             we0, we1;
  logic [AW-1:0]    wa0, wa1;
  logic [DBITS-1:0] wd0, wd1;
  logic [DBITS-1:0] tos, nos;

  assign p_tos   = depth_q - PBITS'(1);
  assign p_nos   = depth_q - PBITS'(2);
  assign a_new   = depth_q[AW-1:0];
  assign a_tos   = p_tos[AW-1:0];
  assign a_nos   = p_nos[AW-1:0];
  assign ge1     = (depth_q != '0);
  assign ge2     = (depth_q >= PBITS'(2));
  assign is_full = (depth_q == PBITS'(DEPTH));
  assign tos     = mem_q[a_tos];
  assign nos     = mem_q[a_nos];

  // Illegal ops fall through with depth/storage untouched.
  always_comb begin
    depth_d = depth_q;
    error_d = error_q;
    code_d  = code_q;
    we0 = 1'b0;
    wa0 = a_new;
    wd0 = push_data;
    we1 = 1'b0;
    wa1 = a_nos;
    wd1 = tos;
    unique case (stack_op)
      OP_NOP: ;
      OP_PSH: begin
        if (is_full) begin
          error_d = 1'b1;
          code_d  = E_OVF;
        end else begin
          we0 = 1'b1;
          depth_d = depth_q + PBITS'(1);
        end
      end
      OP_POP: begin
        if (!ge1) begin
          error_d = 1'b1;
          code_d  = E_UND;
        end else begin
          depth_d = p_tos;
        end
      end
      OP_BIN: begin
        if (!ge2) begin
          error_d = 1'b1;
          code_d  = E_UND;
        end else begin
          we0 = 1'b1;
          wa0 = a_nos;
          wd0 = alu_result;
          depth_d = p_tos;
        end
      end
      OP_UNA: begin
        if (!ge1) begin
          error_d = 1'b1;
          code_d  = E_UND;
        end else begin
          we0 = 1'b1;
          wa0 = a_tos;
          wd0 = alu_result;
        end
      end
      OP_DUP: begin
        if (!ge1) begin
          error_d = 1'b1;
          code_d  = E_UND;
        end else if (is_full) begin
          error_d = 1'b1;
          code_d  = E_OVF;
        end else begin
          we0 = 1'b1;
          wd0 = tos;
          depth_d = depth_q + PBITS'(1);
        end
      end
      OP_SWP: begin
        if (!ge2) begin
          error_d = 1'b1;
          code_d  = E_UND;
        end else begin
          we0 = 1'b1;
          wa0 = a_tos;
          wd0 = nos;
          we1 = 1'b1;
        end
      end
      OP_CLR: begin
        depth_d = '0;
        error_d = 1'b0;
        code_d  = 2'b00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= '0;
      error_q <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      depth_q <= depth_d;
      error_q <= error_d;
      code_q  <= code_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we0 && !rst) mem_q[wa0] <= wd0;
    if (we1 && !rst) mem_q[wa1] <= wd1;
  end

`ifdef ALU_OPERAND_STACK_HWM_EN
  logic [PBITS-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (stack_op == OP_CLR) hwm_d = '0;
    else if (depth_d > hwm_q) hwm_d = depth_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hwm_q <= '0;
    else     hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`endif

  assign operand2 = ge1 ? tos : '0;
  assign operand1 = ge2 ? nos : '0;
  assign depth    = depth_q;
  assign empty    = !ge1;
  assign full     = is_full;
  assign error    = error_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_alu_operand_stack.sv
// Directed self-checking bench for alu_operand_stack (DBITS=32, DEPTH=16).
// Covers hwm when ALU_OPERAND_STACK_HWM_EN is defined.
module tb_alu_operand_stack;

  localparam int DBITS = 32;
  localparam int DEPTH = 16;
  localparam int PBITS = $clog2(DEPTH) + 1;

  localparam logic [2:0] NOP = 3'b000;
  localparam logic [2:0] PSH = 3'b001;
  localparam logic [2:0] POP = 3'b010;
  localparam logic [2:0] BIN = 3'b011;
  localparam logic [2:0] UNA = 3'b100;
  localparam logic [2:0] DUP = 3'b101;
  localparam logic [2:0] SWP = 3'b110;
  localparam logic [2:0] CLR = 3'b111;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       stack_op;
  logic [DBITS-1:0] push_data;
  logic [DBITS-1:0] alu_result;
  logic [DBITS-1:0] operand1;
  logic [DBITS-1:0] operand2;
  logic [PBITS-1:0] depth;
  logic             empty;
  logic             full;
  logic             error;
  logic [1:0]       err_code;
`ifdef ALU_OPERAND_STACK_HWM_EN
  logic [PBITS-1:0] hwm;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_operand_stack #(.DBITS(DBITS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .stack_op  (stack_op),
    .push_data (push_data),
    .alu_result(alu_result),
    .operand1  (operand1),
    .operand2  (operand2),
    .depth     (depth),
    .empty     (empty),
    .full      (full),
    .error     (error),
    .err_code  (err_code)
`ifdef ALU_OPERAND_STACK_HWM_EN
    ,
    .hwm       (hwm)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] op, input logic [31:0] pd,
                      input logic [31:0] ar);
    @(negedge clk);
    stack_op   = op;
    push_data  = pd;
    alu_result = ar;
    @(posedge clk);
    #1;
    stack_op = NOP;
  endtask

  task automatic chk_hwm(input string tag, input int exp);
`ifdef ALU_OPERAND_STACK_HWM_EN
    chk(tag, 32'(hwm), 32'(exp));
`endif
  endtask

  initial begin
    rst = 1'b1;
    stack_op = NOP;
    push_data = '0;
    alu_result = '0;
    #22;
    rst = 1'b0;
    #1;
    chk("rst_depth", 32'(depth), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_code", 32'(err_code), 0);
    chk("rst_op1", operand1, 0);
    chk("rst_op2", operand2, 0);
    chk_hwm("rst_hwm", 0);

    step(PSH, 32'h0000_1000, 0);
    step(PSH, 32'h0000_0001, 0);
    chk("p2_depth", 32'(depth), 2);
    chk("p2_op1", operand1, 32'h0000_1000);
    chk("p2_op2", operand2, 32'h0000_0001);
    chk("p2_empty", 32'(empty), 0);
    chk("p2_error", 32'(error), 0);

    step(BIN, 0, 32'h0000_1001);
    chk("bin_depth", 32'(depth), 1);
    chk("bin_op2", operand2, 32'h0000_1001);
    chk("bin_op1", operand1, 0);

    step(UNA, 0, 32'hFFFF_EFFF);
    chk("una_depth", 32'(depth), 1);
    chk("una_op2", operand2, 32'hFFFF_EFFF);
    chk_hwm("una_hwm", 2);

    step(POP, 0, 0);
    chk("pop_empty", 32'(empty), 1);
    chk("pop_op2", operand2, 0);
    step(POP, 0, 0);
    chk("und_error", 32'(error), 1);
    chk("und_code", 32'(err_code), 1);
    chk("und_depth", 32'(depth), 0);
    step(NOP, 0, 0);
    chk("sticky_error", 32'(error), 1);

    step(CLR, 0, 0);
    chk("clr_error", 32'(error), 0);
    chk("clr_code", 32'(err_code), 0);
    chk_hwm("clr_hwm", 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(PSH, 32'(i), 0);
      if (i == DEPTH - 2) chk("nearfull_full", 32'(full), 0);
    end
    chk("full_full", 32'(full), 1);
    chk("full_error", 32'(error), 0);
    chk("full_depth", 32'(depth), 16);
    chk_hwm("full_hwm", 16);
    step(PSH, 32'h0000_00AA, 0);
    chk("ovf_error", 32'(error), 1);
    chk("ovf_code", 32'(err_code), 2);
    chk("ovf_op2", operand2, 32'h0000_000F);
    chk("ovf_op1", operand1, 32'h0000_000E);
    chk("ovf_depth", 32'(depth), 16);
    step(POP, 0, 0);
    chk("ovf_pop_op2", operand2, 32'h0000_000E);

    step(CLR, 0, 0);
    step(DUP, 0, 0);
    chk("dupe_code", 32'(err_code), 1);
    chk("dupe_depth", 32'(depth), 0);
    chk_hwm("dupe_hwm", 0);

    step(CLR, 0, 0);
    step(PSH, 32'h5, 0);
    step(PSH, 32'h7, 0);
    step(SWP, 0, 0);
    chk("swp_op2", operand2, 32'h5);
    chk("swp_op1", operand1, 32'h7);
    step(DUP, 0, 0);
    chk("dup_depth", 32'(depth), 3);
    chk("dup_op2", operand2, 32'h5);
    chk("dup_op1", operand1, 32'h5);
    step(BIN, 0, 32'hA);
    chk("bin3_depth", 32'(depth), 2);
    chk("bin3_op2", operand2, 32'hA);
    chk("bin3_op1", operand1, 32'h7);
    chk("bin3_error", 32'(error), 0);

    step(CLR, 0, 0);
    step(PSH, 32'h1, 0);
    step(BIN, 0, 32'hDEAD);
    chk("binu_code", 32'(err_code), 1);
    chk("binu_depth", 32'(depth), 1);
    chk("binu_op2", operand2, 32'h1);
    step(SWP, 0, 0);
    chk("swpu_op2", operand2, 32'h1);

    step(CLR, 0, 0);
    step(PSH, 32'h11, 0);
    step(PSH, 32'h22, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_depth", 32'(depth), 0);
    chk("mrst_op1", operand1, 0);
    chk("mrst_op2", operand2, 0);
    chk("mrst_empty", 32'(empty), 1);
    chk_hwm("mrst_hwm", 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_depth", 32'(depth), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
